// File: rtl/resp_misr_checker_if.sv
// Stream/control bundle between a response source and resp_misr_checker.
// Optional feature macro: RESP_XMASK_EN adds the xmask field.
// slave  : the collector side (resp_misr_checker)
// master : the side driving the run control and response stream
interface resp_misr_checker_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic             start;
   logic [CNT_W-1:0] num_patterns;
   logic [WIDTH-1:0] golden;
   logic [WIDTH-1:0] resp_data;
   logic             resp_valid;
   logic             resp_ready;
   logic             busy;
   logic             done;
   logic             pass;
   logic [WIDTH-1:0] signature;
   logic [CNT_W-1:0] count;
`ifdef RESP_XMASK_EN
   logic [WIDTH-1:0] xmask;

   modport slave (
      input  start, num_patterns, golden, resp_data, resp_valid, xmask,
      output resp_ready, busy, done, pass, signature, count
   );
   modport master (
      output start, num_patterns, golden, resp_data, resp_valid, xmask,
      input  resp_ready, busy, done, pass, signature, count
   );
`else
   modport slave (
      input  start, num_patterns, golden, resp_data, resp_valid,
      output resp_ready, busy, done, pass, signature, count
   );
   modport master (
      output start, num_patterns, golden, resp_data, resp_valid,
      input  resp_ready, busy, done, pass, signature, count
   );
`endif
endinterface

// File: rtl/resp_misr_checker.sv
// Response collector: compacts a stream of response vectors in a MISR and
// compares the final signature with a golden value after num_patterns beats.
// Optional feature macro: RESP_XMASK_EN masks each beat with a per-run xmask
// (bits set in xmask are removed before compaction).
// All outputs are registered; resp_ready depends only on state.
module resp_misr_checker #(
   parameter int               WIDTH = 32,
   parameter int               CNT_W = 16,
   parameter logic [WIDTH-1:0] POLY  = 32'h04C11DB7,
   parameter logic [WIDTH-1:0] SEED  = 32'h00000000
) (
   input  logic                 clk,
   input  logic                 rst,
   resp_misr_checker_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One MISR shift: shift left, fold the carried-out bit back through POLY, mix in data.
   function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] m,
                                                   input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] fb;
      fb = m[WIDTH-1] ? POLY : {WIDTH{1'b0}};
      return {m[WIDTH-2:0], 1'b0} ^ fb ^ d;
   endfunction

   state_t           state_r,  state_nxt_s;
   logic [WIDTH-1:0] misr_r,   misr_nxt_s;
   logic [CNT_W-1:0] count_r,  count_nxt_s;
   logic [CNT_W-1:0] num_r,    num_nxt_s;
   logic [WIDTH-1:0] golden_r, golden_nxt_s;
   logic             done_r,   done_nxt_s;
   logic             pass_r,   pass_nxt_s;
   logic             ready_r,  ready_nxt_s;
   logic             busy_r,   busy_nxt_s;
   logic [WIDTH-1:0] data_s;
   logic [WIDTH-1:0] misr_step_s;
   logic [CNT_W-1:0] count_inc_s;
   logic             beat_s;

`ifdef RESP_XMASK_EN
   logic [WIDTH-1:0] xmask_r, xmask_nxt_s;

   // Per-run mask register, captured with an accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xmask_r <= {WIDTH{1'b0}};
      end else begin
         xmask_r <= xmask_nxt_s;
      end
   end

   // Next mask value: latched only on an accepted start.
   always_comb begin
      xmask_nxt_s = xmask_r;
      if (bus.start && (state_r != ST_RUN)) begin
         xmask_nxt_s = bus.xmask;
      end else begin
         xmask_nxt_s = xmask_r;
      end
   end

   assign data_s = bus.resp_data & ~xmask_r;
`else
   assign data_s = bus.resp_data;
`endif

   assign beat_s      = ready_r & bus.resp_valid;
   assign misr_step_s = misr_step(misr_r, data_s);
   assign count_inc_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};

   // State and datapath registers; reset discards any partial run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         misr_r   <= SEED;
         count_r  <= {CNT_W{1'b0}};
         num_r    <= {CNT_W{1'b0}};
         golden_r <= {WIDTH{1'b0}};
         done_r   <= 1'b0;
         pass_r   <= 1'b0;
         ready_r  <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         misr_r   <= misr_nxt_s;
         count_r  <= count_nxt_s;
         num_r    <= num_nxt_s;
         golden_r <= golden_nxt_s;
         done_r   <= done_nxt_s;
         pass_r   <= pass_nxt_s;
         ready_r  <= ready_nxt_s;
         busy_r   <= busy_nxt_s;
      end
   end

   // Next-state and next-output logic for the run sequencer.
   always_comb begin
      state_nxt_s  = state_r;
      misr_nxt_s   = misr_r;
      count_nxt_s  = count_r;
      num_nxt_s    = num_r;
      golden_nxt_s = golden_r;
      done_nxt_s   = done_r;
      pass_nxt_s   = pass_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               misr_nxt_s   = SEED;
               count_nxt_s  = {CNT_W{1'b0}};
               num_nxt_s    = bus.num_patterns;
               golden_nxt_s = bus.golden;
               if (bus.num_patterns == {CNT_W{1'b0}}) begin
                  // Empty run completes immediately on the seed value.
                  state_nxt_s = ST_DONE;
                  done_nxt_s  = 1'b1;
                  pass_nxt_s  = (SEED == bus.golden);
               end else begin
                  state_nxt_s = ST_RUN;
                  done_nxt_s  = 1'b0;
                  pass_nxt_s  = 1'b0;
               end
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_RUN: begin
            if (beat_s) begin
               misr_nxt_s  = misr_step_s;
               count_nxt_s = count_inc_s;
               if (count_inc_s == num_r) begin
                  state_nxt_s = ST_DONE;
                  done_nxt_s  = 1'b1;
                  pass_nxt_s  = (misr_step_s == golden_r);
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            done_nxt_s  = 1'b0;
            pass_nxt_s  = 1'b0;
         end
      endcase
      ready_nxt_s = (state_nxt_s == ST_RUN);
      busy_nxt_s  = (state_nxt_s == ST_RUN);
   end

   assign bus.resp_ready = ready_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.pass       = pass_r;
   assign bus.signature  = misr_r;
   assign bus.count      = count_r;

endmodule

// File: tb/tb_resp_misr_checker.sv
// Self-checking bench for resp_misr_checker: a polynomial-arithmetic reference
// model compared against the DUT every falling edge, plus literal expectations.
module tb_resp_misr_checker;
   localparam int          WIDTH = 32;
   localparam int          CNT_W = 16;
   localparam logic [31:0] POLY  = 32'h04C11DB7;
   localparam logic [31:0] SEED  = 32'h00000000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   resp_misr_checker_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   resp_misr_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W), .POLY(POLY), .SEED(SEED)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: run phase, signature as GF(2) polynomial, beat count.
   int          m_phase = 0;   // 0 idle, 1 collecting, 2 finished
   logic [31:0] m_sig   = SEED;
   int          m_cnt   = 0;
   int          m_num   = 0;
   logic [31:0] m_gold  = 32'h0;
   logic [31:0] m_mask  = 32'h0;
   logic        m_pass  = 1'b0;

   // signature * x mod (x^32 + POLY), then add the data polynomial
   function automatic logic [31:0] mul_x_add(input logic [31:0] s, input logic [31:0] d);
      logic [32:0] t;
      t = {s, 1'b0};
      if (t[32]) t = t ^ {1'b1, POLY};
      return t[31:0] ^ d;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0; m_sig = SEED; m_cnt = 0; m_pass = 1'b0;
      end else if (m_phase != 1 && bus.start) begin
         m_sig = SEED; m_cnt = 0;
         m_num = int'(bus.num_patterns); m_gold = bus.golden;
`ifdef RESP_XMASK_EN
         m_mask = bus.xmask;
`endif
         m_phase = (m_num == 0) ? 2 : 1;
         m_pass  = (m_num == 0) ? (SEED == m_gold) : 1'b0;
      end else if (m_phase == 1 && bus.resp_valid) begin
         m_sig = mul_x_add(m_sig, bus.resp_data & ~m_mask);
         m_cnt = m_cnt + 1;
         if (m_cnt == m_num) begin
            m_phase = 2;
            m_pass  = (m_sig == m_gold);
         end
      end
   end

   always @(negedge clk) begin
      check("model_ready", {63'd0, bus.resp_ready}, {63'd0, m_phase == 1});
      check("model_busy",  {63'd0, bus.busy},       {63'd0, m_phase == 1});
      check("model_done",  {63'd0, bus.done},       {63'd0, m_phase == 2});
      check("model_pass",  {63'd0, bus.pass},       {63'd0, m_pass});
      check("model_sig",   {32'd0, bus.signature},  {32'd0, m_sig});
      check("model_count", {48'd0, bus.count},      64'(m_cnt));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [15:0] n, input logic [31:0] g);
      bus.start = 1'b1; bus.num_patterns = n; bus.golden = g;
      cyc();
      bus.start = 1'b0;
   endtask

   logic [6:0] vpat;

   initial begin
      bus.start = 1'b0; bus.num_patterns = 16'd0; bus.golden = 32'd0;
      bus.resp_data = 32'd0; bus.resp_valid = 1'b0;
`ifdef RESP_XMASK_EN
      bus.xmask = 32'd0;
`endif
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      check("rst_sig",   {32'd0, bus.signature}, 64'h0);
      check("rst_count", {48'd0, bus.count}, 64'h0);
      check("rst_done",  {63'd0, bus.done}, 64'h0);
      check("rst_ready", {63'd0, bus.resp_ready}, 64'h0);

      // single beat
      start_run(16'd1, 32'h00000001);
      check("run_busy", {63'd0, bus.busy}, 64'h1);
      bus.resp_valid = 1'b1; bus.resp_data = 32'h00000001;
      cyc();
      bus.resp_valid = 1'b0;
      check("single_done", {63'd0, bus.done}, 64'h1);
      check("single_pass", {63'd0, bus.pass}, 64'h1);
      check("single_sig",  {32'd0, bus.signature}, 64'h1);

      // two beats
      start_run(16'd2, 32'h00000002);
      bus.resp_valid = 1'b1; bus.resp_data = 32'h00000001; cyc();
      bus.resp_data = 32'h00000000; cyc();
      bus.resp_valid = 1'b0;
      check("two_sig",  {32'd0, bus.signature}, 64'h2);
      check("two_pass", {63'd0, bus.pass}, 64'h1);

      // feedback tap
      start_run(16'd2, 32'h00000000);
      bus.resp_valid = 1'b1; bus.resp_data = 32'h80000000; cyc();
      bus.resp_data = 32'h00000000; cyc();
      bus.resp_valid = 1'b0;
      check("tap_sig",   {32'd0, bus.signature}, 64'h04C11DB7);
      check("tap_pass",  {63'd0, bus.pass}, 64'h0);
      check("tap_count", {48'd0, bus.count}, 64'h2);

      // stalls and ignored start: beats take data 1,4,5,7 -> 0x15
      start_run(16'd4, 32'h00000015);
      vpat = 7'b1011001; // bit i = valid in cycle i
      for (int i = 0; i < 7; i++) begin
         bus.resp_valid = vpat[i];
         bus.resp_data  = 32'(i + 1);
         bus.start      = (i == 2);
         cyc();
         if (i == 5) check("stall_busy", {63'd0, bus.busy}, 64'h1);
      end
      bus.resp_valid = 1'b0; bus.start = 1'b0;
      check("stall_ready_drop", {63'd0, bus.resp_ready}, 64'h0);
      check("stall_done",  {63'd0, bus.done}, 64'h1);
      check("stall_count", {48'd0, bus.count}, 64'h4);
      check("stall_sig",   {32'd0, bus.signature}, 64'h15);
      check("stall_pass",  {63'd0, bus.pass}, 64'h1);
      bus.resp_valid = 1'b1; cyc(); bus.resp_valid = 1'b0;
      check("done_hold_count", {48'd0, bus.count}, 64'h4);

      // zero length
      start_run(16'd0, 32'h00000000);
      check("zero_done", {63'd0, bus.done}, 64'h1);
      check("zero_pass", {63'd0, bus.pass}, 64'h1);
      check("zero_busy", {63'd0, bus.busy}, 64'h0);
      start_run(16'd0, 32'h12345678);
      check("zero_fail_pass", {63'd0, bus.pass}, 64'h0);

`ifdef RESP_XMASK_EN
      bus.xmask = 32'hFFFFFFFF;
      start_run(16'd2, 32'h00000000);
      bus.xmask = 32'h0;
      bus.resp_valid = 1'b1; bus.resp_data = 32'hDEADBEEF; cyc();
      bus.resp_data = 32'h80000001; cyc();
      bus.resp_valid = 1'b0;
      check("xmask_sig",  {32'd0, bus.signature}, 64'h0);
      check("xmask_pass", {63'd0, bus.pass}, 64'h1);
`endif

      // reset mid-run
      start_run(16'd10, 32'h0);
      bus.resp_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.resp_data = 32'(i + 5);
         cyc();
      end
      bus.resp_valid = 1'b0;
      check("mid_count_pre", {48'd0, bus.count}, 64'h3);
      #2 rst = 1'b1;
      #1;
      check("midrst_sig",   {32'd0, bus.signature}, 64'h0);
      check("midrst_count", {48'd0, bus.count}, 64'h0);
      check("midrst_done",  {63'd0, bus.done}, 64'h0);
      check("midrst_ready", {63'd0, bus.resp_ready}, 64'h0);
      cyc();
      rst = 1'b0;
      repeat (2) cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
